// File: rtl/pwm_fade_ctrl.sv
// Register-port sequencer that programs one PWM channel and ramps its duty to a target.
// Optional PWM_FADE_AUTO_OFF_EN: a fade ending at duty 0 also clears the channel enable.
module pwm_fade_ctrl #(
    parameter int CNT_W = 16,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       chan,
    input  logic [DW-1:0]    period,
    input  logic [DW-1:0]    start_duty,
    input  logic [DW-1:0]    target_duty,
    input  logic [DW-1:0]    step,
    input  logic [CNT_W-1:0] interval,
    output logic             wr,
    output logic [6:0]       adrs,
    output logic [DW-1:0]    din,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_PER  = 3'd1;
    localparam logic [2:0] WR_EN   = 3'd2;
    localparam logic [2:0] WR_D0   = 3'd3;
    localparam logic [2:0] WAIT    = 3'd4;
    localparam logic [2:0] WR_DUTY = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
`ifdef PWM_FADE_AUTO_OFF_EN
    localparam logic [2:0] WR_OFF  = 3'd7;
`endif

    logic [2:0]       state_q;
    logic [2:0]       chan_q;
    logic [DW-1:0]    per_q, cur_q, tgt_q, step_q;
    logic [CNT_W-1:0] ivl_q, cnt_q;
    logic [6:0]       base;
    logic             up;
    logic [DW-1:0]    diff, nxt;
    logic [2:0]       fin_state;

    assign base = {1'b0, chan_q, 3'b000} + {2'b00, chan_q, 2'b00};

    // Distance to target is compared before stepping, so cur never wraps.
    always_comb begin
        up   = tgt_q > cur_q;
        diff = up ? (tgt_q - cur_q) : (cur_q - tgt_q);
        if (diff <= step_q) nxt = tgt_q;
        else if (up)        nxt = cur_q + step_q;
        else                nxt = cur_q - step_q;
    end

`ifdef PWM_FADE_AUTO_OFF_EN
    assign fin_state = (tgt_q == '0) ? WR_OFF : DONE;
`else
    assign fin_state = DONE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
            per_q   <= '0;
            cur_q   <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            ivl_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q != IDLE && abort) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (start && !abort) begin
                    chan_q  <= chan;
                    per_q   <= period;
                    cur_q   <= (start_duty > period) ? period : start_duty;
                    tgt_q   <= (target_duty > period) ? period : target_duty;
                    step_q  <= (step == '0) ? DW'(1) : step;
                    ivl_q   <= interval;
                    state_q <= WR_PER;
                end
                WR_PER: state_q <= WR_EN;
                WR_EN:  state_q <= WR_D0;
                WR_D0, WR_DUTY: begin
                    if (cur_q == tgt_q) state_q <= fin_state;
                    else begin
                        cnt_q   <= ivl_q;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        cur_q   <= nxt;
                        state_q <= WR_DUTY;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef PWM_FADE_AUTO_OFF_EN
                WR_OFF: state_q <= DONE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr   = 1'b0;
        adrs = '0;
        din  = '0;
        case (state_q)
            WR_PER:  begin wr = 1'b1; adrs = base + 7'd4; din = per_q; end
            WR_EN:   begin wr = 1'b1; adrs = base;        din = DW'(1); end
            WR_D0,
            WR_DUTY: begin wr = 1'b1; adrs = base + 7'd8; din = cur_q; end
`ifdef PWM_FADE_AUTO_OFF_EN
            WR_OFF:  begin wr = 1'b1; adrs = base;        din = '0; end
`endif
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Randomized bench for pwm_fade_ctrl: expected write stream built from fade rules per command.
module tb_pwm_fade_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [2:0]  chan = '0;
    logic [31:0] period = '0, start_duty = '0, target_duty = '0, step = '0;
    logic [15:0] interval = '0;
    logic        wr, busy, done;
    logic [6:0]  adrs;
    logic [31:0] din;

    int vecs = 0;
    int errs = 0;

    pwm_fade_ctrl #(.CNT_W(16), .DW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .chan(chan),
        .period(period), .start_duty(start_duty), .target_duty(target_duty),
        .step(step), .interval(interval), .wr(wr), .adrs(adrs), .din(din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        chan        = 3'($urandom);
        period      = $urandom;
        start_duty  = $urandom;
        target_duty = $urandom;
        step        = $urandom;
        interval    = 16'($urandom);
    endtask

    // Issue one command and check every write (address, data, cycle) plus done/busy timing.
    task automatic run_cmd(input logic [2:0] c, input logic [31:0] p, input logic [31:0] sd,
                           input logic [31:0] td, input logic [31:0] st, input logic [15:0] iv);
        int          eadr[$];
        logic [31:0] edat[$];
        int          etim[$];
        int          base, tt, t, dt;
        logic [31:0] cur, tgt, s;
        bit          fin;
        base = c * 12;
        cur  = (sd < p) ? sd : p;
        tgt  = (td < p) ? td : p;
        s    = (st == 0) ? 32'd1 : st;
        eadr.push_back(base + 4); edat.push_back(p); etim.push_back(1);
        eadr.push_back(base);     edat.push_back(1); etim.push_back(2);
        tt = 3;
        eadr.push_back(base + 8); edat.push_back(cur); etim.push_back(tt);
        while (cur != tgt) begin
            if (tgt > cur) cur = (tgt - cur <= s) ? tgt : cur + s;
            else           cur = (cur - tgt <= s) ? tgt : cur - s;
            tt += int'(iv) + 2;
            eadr.push_back(base + 8); edat.push_back(cur); etim.push_back(tt);
        end
`ifdef PWM_FADE_AUTO_OFF_EN
        if (tgt == 0) begin
            tt += 1;
            eadr.push_back(base); edat.push_back(0); etim.push_back(tt);
        end
`endif
        dt = tt + 1;

        @(negedge clk);
        chan = c; period = p; start_duty = sd; target_duty = td; step = st; interval = iv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        t = 1;
        fin = 0;
        while (!fin && t < 20000) begin
            if (wr) begin
                if (eadr.size() == 0) chk("extra_wr", 1, 0);
                else begin
                    chk("adrs", adrs, eadr.pop_front());
                    chk("din", din, edat.pop_front());
                    chk("wr_cycle", t, etim.pop_front());
                end
            end
            if (done) begin
                chk("done_cycle", t, dt);
                chk("busy_at_done", busy, 1);
                chk("writes_left", eadr.size(), 0);
                fin = 1;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
    endtask

    initial begin
        int n20;
        bit seen;
        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_wr", wr, 0); chk("rst_busy", busy, 0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr || busy || done || adrs != 0 || din != 0) chk("idle_outputs", 1, 0);
            else chk("idle_outputs", 0, 0);
        end

        // Directed cases
        run_cmd(3'd2, 32'd100, 32'd10, 32'd40, 32'd10, 16'd3);
        run_cmd(3'd7, 32'd50,  32'd50, 32'd3,  32'd20, 16'd0);
        run_cmd(3'd0, 32'd5,   32'd9,  32'd8,  32'd0,  16'd2);
        run_cmd(3'd1, 32'd10,  32'd4,  32'd0,  32'd2,  16'd1);
        run_cmd(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h8000_0000, 16'd0);
        run_cmd(3'd4, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFF, 16'd1);

        // Abort during second WAIT of the up ramp, with an ignored start while busy
        @(negedge clk);
        chan = 3'd2; period = 100; start_duty = 10; target_duty = 40; step = 10; interval = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n20 = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (wr && adrs == 7'h20 && din == 10) begin
                @(negedge clk);
                chan = 3'd5; period = 7; start_duty = 1; target_duty = 2; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("busy_ignored_start", busy, 1);
            end else if (wr && adrs == 7'h20 && din == 20) begin
                chk("second_duty", din, 20);
                seen = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) chk("abort_setup_timeout", 0, 1);
        @(negedge clk);
        chk("wait_no_wr", wr, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 30; i++) begin
            chk("post_abort_quiet", {wr, done, busy}, 3'b000);
            @(negedge clk);
        end

        // abort with start in IDLE: command dropped
        chan = 3'd6; period = 20; start_duty = 1; target_duty = 9; step = 1; interval = 0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("abort_start_idle", {wr, busy}, 2'b00);
            @(negedge clk);
        end

        // Async reset in the middle of a write
        chan = 3'd3; period = 30; start_duty = 0; target_duty = 30; step = 5; interval = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_wr", wr, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_wr", wr, 0);
        chk("async_rst_adrs", adrs, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("after_rst_idle", {wr, busy, done}, 3'b000);

        // Randomized commands
        for (int k = 0; k < 25; k++)
            run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 200), $urandom_range(0, 250),
                    $urandom_range(0, 250), $urandom_range(0, 40), 16'($urandom_range(0, 4)));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
